// File: rtl/spi_data_shifter.sv
// Byte-wide SPI master datapath: shifts MOSI and samples MISO on the
// leading/trailing edge strobes produced by spi_clock_generator.
module spi_data_shifter #(
    parameter int SPI_MODE  = 0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_Gen_Start,
    input  logic       i_Gen_Ready,
    input  logic       i_Leading_Edge,
    input  logic       i_Trailing_Edge,
    output logic       o_SPI_MOSI,
    input  logic       i_SPI_MISO,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV,
    output logic       o_Abort
);
    localparam logic CPHA = (SPI_MODE % 2) == 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        SHIFT,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] tx_byte;
    logic [7:0] rx_shift;
    logic [3:0] tx_cnt;
    logic [3:0] rx_cnt;
    logic [2:0] wait_cnt;

    logic       active;
    logic       drive_evt;
    logic       sample_evt;
    logic [2:0] bit_idx;
    logic [3:0] rx_cnt_nxt;
    logic [7:0] rx_next;
    logic       first_bit;

    assign active     = (state == WAIT_BUSY) || (state == SHIFT);
    assign drive_evt  = active && (tx_cnt < 4'd8) &&
                        (CPHA ? i_Leading_Edge : i_Trailing_Edge);
    // rx_cnt saturates so stray strobes cannot disturb a full byte
    assign sample_evt = active && (rx_cnt < 4'd8) &&
                        (CPHA ? i_Trailing_Edge : i_Leading_Edge);
    assign rx_cnt_nxt = rx_cnt + {3'd0, sample_evt};
    assign bit_idx    = MSB_FIRST ? (3'd7 - tx_cnt[2:0]) : tx_cnt[2:0];
    assign rx_next    = MSB_FIRST ? {rx_shift[6:0], i_SPI_MISO}
                                  : {i_SPI_MISO, rx_shift[7:1]};
    assign first_bit  = MSB_FIRST ? i_TX_Byte[7] : i_TX_Byte[0];

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= IDLE;
            o_TX_Ready  <= 1'b1;
            o_Gen_Start <= 1'b0;
            o_SPI_MOSI  <= 1'b0;
            o_RX_Byte   <= 8'h00;
            o_RX_DV     <= 1'b0;
            o_Abort     <= 1'b0;
            tx_byte     <= 8'h00;
            rx_shift    <= 8'h00;
            tx_cnt      <= 4'd0;
            rx_cnt      <= 4'd0;
            wait_cnt    <= 3'd0;
        end else begin
            o_Gen_Start <= 1'b0;
            o_RX_DV     <= 1'b0;
            o_Abort     <= 1'b0;

            if (drive_evt) begin
                o_SPI_MOSI <= tx_byte[bit_idx];
                tx_cnt     <= tx_cnt + 4'd1;
            end
            if (sample_evt) begin
                rx_shift <= rx_next;
                rx_cnt   <= rx_cnt_nxt;
            end

            unique case (state)
                IDLE: begin
                    if (i_TX_DV) begin
                        tx_byte     <= i_TX_Byte;
                        o_SPI_MOSI  <= first_bit;
                        tx_cnt      <= CPHA ? 4'd0 : 4'd1;
                        rx_cnt      <= 4'd0;
                        wait_cnt    <= 3'd0;
                        o_TX_Ready  <= 1'b0;
                        o_Gen_Start <= 1'b1;
                        state       <= START;
                    end
                end
                START: state <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (!i_Gen_Ready) begin
                        state <= SHIFT;
                    end else if (wait_cnt == 3'd4) begin
                        o_Abort    <= 1'b1;
                        o_SPI_MOSI <= 1'b0;
                        o_TX_Ready <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                SHIFT: begin
                    // generator idle again: byte complete or cut short
                    if (i_Gen_Ready) begin
                        if (rx_cnt_nxt == 4'd8) begin
                            state <= DONE;
                        end else begin
                            o_Abort    <= 1'b1;
                            o_SPI_MOSI <= 1'b0;
                            o_TX_Ready <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                DONE: begin
                    o_RX_Byte  <= rx_shift;
                    o_RX_DV    <= 1'b1;
                    o_SPI_MOSI <= 1'b0;
                    o_TX_Ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_data_shifter.sv
// Bench for spi_data_shifter: three instances (mode 0 MSB, mode 3 MSB,
// mode 0 LSB) driven in lockstep by a behavioural edge generator/slave.
module tb_spi_data_shifter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] tx_byte = 8'h00;
    logic       tx_dv = 1'b0;
    logic       gen_ready = 1'b1;
    logic       lead = 1'b0;
    logic       trail = 1'b0;
    logic       slave_miso = 1'b0;
    logic       loop_en = 1'b0;

    logic [2:0] tx_ready, gen_start, mosi, rx_dv, abort_p, miso;
    logic [7:0] rx_byte [3];

    assign miso = loop_en ? mosi : {3{slave_miso}};

    spi_data_shifter #(.SPI_MODE(0), .MSB_FIRST(1'b1)) d0 (
        .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv),
        .o_TX_Ready(tx_ready[0]), .o_Gen_Start(gen_start[0]),
        .i_Gen_Ready(gen_ready), .i_Leading_Edge(lead),
        .i_Trailing_Edge(trail), .o_SPI_MOSI(mosi[0]),
        .i_SPI_MISO(miso[0]), .o_RX_Byte(rx_byte[0]),
        .o_RX_DV(rx_dv[0]), .o_Abort(abort_p[0]));

    spi_data_shifter #(.SPI_MODE(3), .MSB_FIRST(1'b1)) d3 (
        .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv),
        .o_TX_Ready(tx_ready[1]), .o_Gen_Start(gen_start[1]),
        .i_Gen_Ready(gen_ready), .i_Leading_Edge(lead),
        .i_Trailing_Edge(trail), .o_SPI_MOSI(mosi[1]),
        .i_SPI_MISO(miso[1]), .o_RX_Byte(rx_byte[1]),
        .o_RX_DV(rx_dv[1]), .o_Abort(abort_p[1]));

    spi_data_shifter #(.SPI_MODE(0), .MSB_FIRST(1'b0)) dl (
        .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv),
        .o_TX_Ready(tx_ready[2]), .o_Gen_Start(gen_start[2]),
        .i_Gen_Ready(gen_ready), .i_Leading_Edge(lead),
        .i_Trailing_Edge(trail), .o_SPI_MOSI(mosi[2]),
        .i_SPI_MISO(miso[2]), .o_RX_Byte(rx_byte[2]),
        .o_RX_DV(rx_dv[2]), .o_Abort(abort_p[2]));

    localparam bit MSB_OF [3] = '{1'b1, 1'b1, 1'b0};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = b[7-k];
        return r;
    endfunction

    // Generator + slave model. Slave holds bit k of slave_byte (MSB first)
    // from leading edge k through trailing edge k, junk otherwise.
    int         gen_edges = 16;
    int         gen_gap = 1;
    bit         gen_en = 1'b1;
    bit         gen_stall = 1'b0;
    bit         gen_busy = 1'b0;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] cap [3];

    initial forever begin
        @(negedge clk);
        if (gen_start[0] && gen_en) begin
            gen_busy = 1'b1;
            gen_ready = 1'b0;
            for (int i = 0; i < 3; i++) cap[i] = 8'h00;
            repeat (2) @(negedge clk);
            for (int e = 0; e < gen_edges; e++) begin
                if (e % 2 == 0) begin
                    lead = 1'b1;
                    slave_miso = slave_byte[7 - e/2];
                    cap[0][e/2] = mosi[0];
                    cap[2][e/2] = mosi[2];
                end else begin
                    trail = 1'b1;
                    cap[1][e/2] = mosi[1];
                end
                @(negedge clk);
                lead = 1'b0;
                trail = 1'b0;
                if (e % 2 == 1) slave_miso = 1'($urandom_range(0, 1));
                repeat (gen_gap) @(negedge clk);
            end
            if (!gen_stall) gen_ready = 1'b1;
            gen_busy = 1'b0;
        end
    end

    int         rxdv_cnt [3] = '{0, 0, 0};
    int         abort_cnt [3] = '{0, 0, 0};
    int         gs_cnt [3] = '{0, 0, 0};
    logic [7:0] rx_last [3];
    int         b_rx [3];
    int         b_ab [3];
    int         b_gs [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rx_dv[i]) begin
                rxdv_cnt[i] <= rxdv_cnt[i] + 1;
                rx_last[i]  <= rx_byte[i];
            end
            if (abort_p[i]) abort_cnt[i] <= abort_cnt[i] + 1;
            if (gen_start[i]) gs_cnt[i] <= gs_cnt[i] + 1;
        end
    end

    task automatic snap();
        for (int i = 0; i < 3; i++) begin
            b_rx[i] = rxdv_cnt[i];
            b_ab[i] = abort_cnt[i];
            b_gs[i] = gs_cnt[i];
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        int n = 0;
        while (!tx_ready[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("tx_ready_timeout", 32'(tx_ready[0]), 1);
        tx_byte = b;
        tx_dv = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
    endtask

    task automatic wait_done(input int nrx);
        int n = 0;
        while (rxdv_cnt[0] < b_rx[0] + nrx && abort_cnt[0] == b_ab[0]
               && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 400) chk("done_timeout", 32'(rxdv_cnt[0] - b_rx[0]), 32'(nrx));
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_d%0d_txrdy", nm, i), 32'(tx_ready[i]), 1);
            chk($sformatf("%s_d%0d_gstart", nm, i), 32'(gen_start[i]), 0);
            chk($sformatf("%s_d%0d_mosi", nm, i), 32'(mosi[i]), 0);
            chk($sformatf("%s_d%0d_rxdv", nm, i), 32'(rx_dv[i]), 0);
            chk($sformatf("%s_d%0d_abort", nm, i), 32'(abort_p[i]), 0);
            chk($sformatf("%s_d%0d_rxbyte", nm, i), 32'(rx_byte[i]), 0);
        end
    endtask

    task automatic run_xfer(input string nm, input logic [7:0] tx,
                            input logic [7:0] sl, input bit lp,
                            input logic [7:0] em, input logic [7:0] el);
        slave_byte = sl;
        loop_en = lp;
        #1;
        snap();
        start_tx(tx);
        wait_done(1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_d%0d_rx", nm, i), 32'(rx_last[i]),
                32'(i == 2 ? el : em));
            chk($sformatf("%s_d%0d_mosi_seq", nm, i), 32'(cap[i]),
                32'(MSB_OF[i] ? rev8(tx) : tx));
            chk($sformatf("%s_d%0d_rxdv_n", nm, i),
                32'(rxdv_cnt[i] - b_rx[i]), 1);
            chk($sformatf("%s_d%0d_abort_n", nm, i),
                32'(abort_cnt[i] - b_ab[i]), 0);
            chk($sformatf("%s_d%0d_gstart_n", nm, i),
                32'(gs_cnt[i] - b_gs[i]), 1);
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slave;
        bit         loop;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rt, rs;
        bit         rl;
        int         n;

        tbl[0] = '{8'hA5, 8'h00, 1'b1, 8'hA5, 8'hA5};
        tbl[1] = '{8'h3C, 8'hC3, 1'b0, 8'hC3, 8'hC3};
        tbl[2] = '{8'h01, 8'h00, 1'b1, 8'h01, 8'h01};
        tbl[3] = '{8'h01, 8'h80, 1'b0, 8'h80, 8'h01};
        tbl[4] = '{8'h12, 8'h12, 1'b0, 8'h12, 8'h48};
        tbl[5] = '{8'h55, 8'hAA, 1'b0, 8'hAA, 8'h55};
        tbl[6] = '{8'hFF, 8'h00, 1'b0, 8'h00, 8'h00};
        tbl[7] = '{8'h81, 8'h0F, 1'b0, 8'h0F, 8'hF0};

        repeat (3) @(negedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++)
            run_xfer($sformatf("vec%0d", v), tbl[v].tx, tbl[v].slave,
                     tbl[v].loop, tbl[v].exp_m, tbl[v].exp_l);

        for (int r = 0; r < 20; r++) begin
            rt = 8'($urandom);
            rs = 8'($urandom);
            rl = 1'($urandom_range(0, 1));
            gen_gap = $urandom_range(0, 2);
            run_xfer($sformatf("rand%0d", r), rt, rs, rl,
                     rl ? rt : rs, rl ? rt : rev8(rs));
        end
        gen_gap = 1;

        // request while busy is dropped, not queued
        loop_en = 1'b1;
        #1;
        snap();
        start_tx(8'h12);
        repeat (8) @(negedge clk);
        tx_byte = 8'hFF;
        tx_dv = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        wait_done(1);
        repeat (20) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy_dv_d%0d_rx", i), 32'(rx_last[i]), 32'h12);
            chk($sformatf("busy_dv_d%0d_rxdv_n", i),
                32'(rxdv_cnt[i] - b_rx[i]), 1);
            chk($sformatf("busy_dv_d%0d_gstart_n", i),
                32'(gs_cnt[i] - b_gs[i]), 1);
        end

        // back-to-back: second request in the first IDLE cycle
        snap();
        start_tx(8'h55);
        n = 0;
        while (!tx_ready[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_idle_rxdv", 32'(rx_dv[0]), 1);
        chk("b2b_first_rx", 32'(rx_byte[0]), 32'h55);
        tx_byte = 8'hAA;
        tx_dv = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        wait_done(2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_d%0d_rx", i), 32'(rx_last[i]), 32'hAA);
            chk($sformatf("b2b_d%0d_rxdv_n", i),
                32'(rxdv_cnt[i] - b_rx[i]), 2);
            chk($sformatf("b2b_d%0d_gstart_n", i),
                32'(gs_cnt[i] - b_gs[i]), 2);
        end

        // reset after 4 leading edges
        gen_edges = 7;
        gen_stall = 1'b1;
        #1;
        snap();
        start_tx(8'h3C);
        @(negedge clk);
        n = 0;
        while (gen_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        gen_ready = 1'b1;
        gen_stall = 1'b0;
        gen_edges = 16;
        repeat (10) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("midrst_d%0d_rxdv_n", i),
                32'(rxdv_cnt[i] - b_rx[i]), 0);
        run_xfer("after_rst", 8'h81, 8'h00, 1'b1, 8'h81, 8'h81);

        // generator goes idle after 3 edges
        gen_edges = 3;
        #1;
        snap();
        start_tx(8'h5A);
        wait_done(1);
        gen_edges = 16;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("short_d%0d_abort_n", i),
                32'(abort_cnt[i] - b_ab[i]), 1);
            chk($sformatf("short_d%0d_rxdv_n", i),
                32'(rxdv_cnt[i] - b_rx[i]), 0);
            chk($sformatf("short_d%0d_rxbyte", i), 32'(rx_byte[i]), 32'h81);
            chk($sformatf("short_d%0d_txrdy", i), 32'(tx_ready[i]), 1);
        end

        // generator never acknowledges the start
        gen_en = 1'b0;
        #1;
        snap();
        start_tx(8'h77);
        wait_done(1);
        gen_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("nobusy_d%0d_abort_n", i),
                32'(abort_cnt[i] - b_ab[i]), 1);
            chk($sformatf("nobusy_d%0d_rxdv_n", i),
                32'(rxdv_cnt[i] - b_rx[i]), 0);
        end

        run_xfer("recover", 8'hC3, 8'h3C, 1'b0, 8'h3C, 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_data_shifter.md
Name: spi_data_shifter

Overview:
- Byte-level SPI master datapath. It sits directly downstream of spi_clock_generator, consumes that block's o_Leading_Edge and o_Trailing_Edge strobes, and drives MOSI and samples MISO at the correct edges.
- Upstream, it accepts a byte from the host through a valid/ready handshake and starts the generator with a one-cycle pulse on the generator's i_TX_DV.
- On completion it returns the received byte with a one-cycle valid pulse.
- The generator produces exactly 8 leading and 8 trailing edges per transaction, so the word width is fixed at 8.

Parameters:
- SPI_MODE, 0, SPI mode 0-3. CPHA = SPI_MODE[0]. CPOL is handled by the generator and is unused here. Must match the generator's SPI_MODE.
- MSB_FIRST, 1, 1 = bit 7 transmitted and received first; 0 = bit 0 first.

Ports:
- i_Clk  in  1  system clock; all logic is on its rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_TX_Byte  in  8  byte to transmit; captured when i_TX_DV && o_TX_Ready.
- i_TX_DV  in  1  host request strobe.
- o_TX_Ready  out  1  high only in IDLE; registered.
- o_Gen_Start  out  1  one-cycle pulse to the generator's i_TX_DV.
- i_Gen_Ready  in  1  generator's o_TX_Ready.
- i_Leading_Edge  in  1  one-cycle strobe from the generator.
- i_Trailing_Edge  in  1  one-cycle strobe from the generator.
- o_SPI_MOSI  out  1  serial data out; registered.
- i_SPI_MISO  in  1  serial data in.
- o_RX_Byte  out  8  last received byte; holds until the next completion.
- o_RX_DV  out  1  one-cycle pulse when o_RX_Byte updates.
- o_Abort  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset values (asynchronous, i_Rst=1):
  - state = IDLE, o_TX_Ready=1, o_Gen_Start=0, o_SPI_MOSI=0.
  - o_RX_Byte=8'h00, o_RX_DV=0, o_Abort=0, tx_cnt=0, rx_cnt=0.
- Reset asserted mid-transfer:
  - Reset values are forced immediately.
  - The partial byte is discarded and no o_RX_DV is produced.
- FSM states: IDLE, START, WAIT_BUSY, SHIFT, DONE.
- IDLE:
  - On i_TX_DV=1, latch i_TX_Byte into the shift register.
  - Drive o_SPI_MOSI with the first bit (bit 7 if MSB_FIRST, else bit 0), for both CPHA values.
  - Set tx_cnt=1 if CPHA=0, else 0. Set rx_cnt=0. Go to START; o_TX_Ready drops the next cycle.
- START:
  - o_Gen_Start=1 for exactly this cycle. Next state is WAIT_BUSY.
- WAIT_BUSY:
  - Stay until i_Gen_Ready=0, then go to SHIFT.
  - Edge strobes arriving in this state are processed exactly as in SHIFT.
  - Limit: more than 4 cycles here with i_Gen_Ready=1 -> o_Abort pulse, then IDLE.
- SHIFT, CPHA=0:
  - i_Leading_Edge: sample i_SPI_MISO into the RX shift register; rx_cnt++.
  - i_Trailing_Edge with tx_cnt<8: drive the next bit on MOSI; tx_cnt++.
  - Trailing edge with tx_cnt==8: MOSI holds the last bit.
- SHIFT, CPHA=1:
  - i_Leading_Edge with tx_cnt<8: drive the next bit on MOSI; tx_cnt++.
  - i_Trailing_Edge: sample MISO; rx_cnt++.
- Sampling and counting rules:
  - Sampling uses the i_SPI_MISO value present in the same i_Clk cycle as the strobe.
  - Leading and trailing strobes asserted in the same cycle: both are processed; not expected from the generator.
  - Strobes outside WAIT_BUSY/SHIFT are ignored.
  - rx_cnt saturates at 8; extra strobes do not corrupt RX data.
- Exit from SHIFT:
  - When rx_cnt==8 and i_Gen_Ready=1, go to DONE.
  - If i_Gen_Ready returns to 1 with rx_cnt<8: o_Abort pulse, no o_RX_DV, then IDLE.
- DONE:
  - o_RX_Byte <= assembled byte, o_RX_DV=1 for one cycle, o_SPI_MOSI <= 0.
  - Next state is IDLE; o_TX_Ready=1 the cycle after DONE.
- Host handshake:
  - i_TX_DV while o_TX_Ready=0 is ignored; it is not queued.
  - Back-to-back: i_TX_DV in the first IDLE cycle after DONE is accepted.
- Latency:
  - i_TX_DV accepted at cycle N -> o_Gen_Start at cycle N+1.
  - o_RX_DV occurs 1-2 cycles after the generator's ready returns high.
- Bit order:
  - MSB_FIRST=1: shift left; received bits enter at bit 0.
  - MSB_FIRST=0: mirrored.

Test Plan:
- Mode 0, real spi_clock_generator (CLKS_PER_HALF_BIT=2), MISO looped to MOSI, TX 8'hA5 -> MOSI sequence 1,0,1,0,0,1,0,1, each bit stable across its leading edge; o_RX_Byte=8'hA5; single o_RX_DV pulse; o_Abort never set.
- Mode 3, slave model returns 8'hC3 (MISO changes on leading, stable at trailing), TX 8'h3C -> o_RX_Byte=8'hC3; MOSI changes only on leading-edge cycles.
- MSB_FIRST=0, mode 0, loopback, TX 8'h01 -> first MOSI bit=1, remaining 7 bits=0; o_RX_Byte=8'h01.
- i_TX_DV pulsed with 8'hFF mid-transfer of 8'h12 -> ignored; exactly one o_RX_DV with 8'h12; o_Gen_Start pulsed once.
- Back-to-back 8'h55 then 8'hAA, second i_TX_DV in the first IDLE cycle -> two o_RX_DV pulses with 8'h55 then 8'hAA (loopback); 16 leading + 16 trailing edges total.
- Two error and reset cases:
  - Assert i_Rst after 4 leading edges -> outputs at reset values in the same cycle; no o_RX_DV; next transfer of 8'h81 completes correctly.
  - Stub generator raises i_Gen_Ready after 3 edges -> o_Abort=1 for one cycle; o_RX_Byte unchanged.
